multicycle_control: RTL

//  Moore/Mealy FSM that sequences the 16-bit multicycle datapath: fetch, decode, execute, memory, write-back.

---
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle datapath and its sequencing FSM.
// The datapath side (master) supplies instruction and handshake inputs; the controller (slave) drives strobes.
interface multicycle_control_if;
  localparam int unsigned OPC_W = 4;
  localparam int unsigned SEL_W = 2;

  logic             run;
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic [SEL_W-1:0] pc_src;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [SEL_W-1:0] reg_dst;
  logic [SEL_W-1:0] mem_to_reg;
  logic             alu_src_a;
  logic [SEL_W-1:0] alu_src_b;
  logic [OPC_W-1:0] alu_op;
  logic             instr_done;
  logic             fault;
  logic [OPC_W-1:0] state;

  modport master (
    output run, opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           instr_done, fault, state
  );

  modport slave (
    input  run, opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           instr_done, fault, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Sequencing FSM for the 16-bit multicycle datapath: fetch, decode, execute, memory, write-back,
// with a bounded memory wait that falls into a sticky fault state on timeout.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                  clock,
  input logic                  reset_n,
  multicycle_control_if.slave  bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OPC_W = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_BRANCH = 4'd5,
    S_JUMP   = 4'd6,
    S_JAL    = 4'd7,
    S_JR     = 4'd8,
    S_ADDR   = 4'd9,
    S_MEM_RD = 4'd10,
    S_MEM_WR = 4'd11,
    S_WB_ALU = 4'd12,
    S_WB_MEM = 4'd13,
    S_FAULT  = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_is_wait;
  logic             w_timeout;

  logic             w_pc_write;
  logic             w_pc_write_cond;
  logic [SEL_W-1:0] w_pc_src;
  logic             w_iord;
  logic             w_mem_read;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_reg_write;
  logic [SEL_W-1:0] w_reg_dst;
  logic [SEL_W-1:0] w_mem_to_reg;
  logic             w_alu_src_a;
  logic [SEL_W-1:0] w_alu_src_b;
  logic [OPC_W-1:0] w_alu_op;
  logic             w_instr_done;
  logic             w_fault;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Any state change re-arms the counter, so it restarts on every entry to a wait state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          r_wait_cnt <= '0;
    else if (w_next != r_state)            r_wait_cnt <= '0;
    else if (w_is_wait && !bus.mem_ready)  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout = (r_wait_cnt == CNT_W'(MEM_WAIT_MAX)) && !bus.mem_ready;

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_src        = '0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = '0;
    w_mem_to_reg    = '0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = '0;
    w_alu_op        = '0;
    w_instr_done    = 1'b0;
    w_fault         = 1'b0;
    case (r_state)
      S_IDLE: if (bus.run) w_next = S_FETCH;
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'd2;
        case (bus.opcode)
          4'd1:       w_next = S_EXEC_I;
          4'd3, 4'd4: w_next = S_BRANCH;
          4'd5:       w_next = S_JUMP;
          4'd6:       w_next = S_JAL;
          4'd7:       w_next = S_JR;
          4'd8, 4'd15: w_next = S_ADDR;
          default:    w_next = S_EXEC_R;
        endcase
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = (bus.opcode >= 4'd11 && bus.opcode <= 4'd13) ? 2'd3 : 2'd0;
        w_alu_op    = bus.opcode;
        w_next      = S_WB_ALU;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        w_alu_op    = bus.opcode;
        w_next      = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (bus.opcode == 4'd1) ? 2'd0 : 2'd1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = bus.opcode;
        w_pc_src        = 2'd1;
        w_pc_write_cond = (bus.opcode == 4'd3) ? bus.zero : !bus.zero;
        w_instr_done    = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_src     = 2'd2;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        w_pc_write   = 1'b1;
        w_pc_src     = 2'd2;
        w_reg_write  = 1'b1;
        w_reg_dst    = 2'd2;
        w_mem_to_reg = 2'd2;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JR: begin
        w_pc_write   = 1'b1;
        w_pc_src     = 2'd3;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        w_alu_op    = bus.opcode;
        w_next      = (bus.opcode == 4'd15) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (bus.mem_ready)  w_next = S_WB_MEM;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEM_WR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (bus.mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'd1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_FAULT: w_fault = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.pc_src        = w_pc_src;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.reg_write     = w_reg_write;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.instr_done    = w_instr_done;
  assign bus.fault         = w_fault;
  assign bus.state         = r_state;
endmodule
